// File: rtl/flight_cmd_sched_if.sv
// flight_cmd_sched_if: command-source bus between the three sources and the scheduler
//   req_valid[2:0] : per-source request (0 failsafe, 1 autopilot, 2 pilot)
//   req_ready[2:0] : per-source accept-ready
//   req_alt/req_dir: packed per-source payloads, source i at [i*W +: W]
//   altcmd/dircmd  : registered commands to dronetop
//   grant_id       : owner of the current command, 3 = none
//   active         : a source-issued command is in force
//   wdog_trip      : sticky watchdog flag
interface flight_cmd_sched_if #(
   parameter int ALT_W = 2,
   parameter int DIR_W = 3
);
   logic [2:0]         req_valid;
   logic [2:0]         req_ready;
   logic [3*ALT_W-1:0] req_alt;
   logic [3*DIR_W-1:0] req_dir;
   logic [ALT_W-1:0]   altcmd;
   logic [DIR_W-1:0]   dircmd;
   logic [1:0]         grant_id;
   logic               active;
   logic               wdog_trip;
   modport master (
      output req_valid, req_alt, req_dir,
      input  req_ready, altcmd, dircmd, grant_id, active, wdog_trip
   );
   modport slave (
      input  req_valid, req_alt, req_dir,
      output req_ready, altcmd, dircmd, grant_id, active, wdog_trip
   );
endinterface

// File: rtl/flight_cmd_sched.sv
// flight_cmd_sched: fixed-priority command arbiter with dwell hold, failsafe preemption and watchdog
//   clk    : clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : flight_cmd_sched_if slave (requests in, ready and registered commands out)
module flight_cmd_sched #(
   parameter int               ALT_W       = 2,
   parameter int               DIR_W       = 3,
   parameter int               HOLD_CYC    = 8,
   parameter int               WDOG_CYC    = 1000,
   parameter logic [ALT_W-1:0] ALT_NEUTRAL = '0,
   parameter logic [DIR_W-1:0] DIR_NEUTRAL = '0
) (
   input logic                 clk,
   input logic                 resetn,
   flight_cmd_sched_if.slave   bus
);
   typedef enum logic {READY, HOLD} state_t;
   localparam int HW = $clog2(HOLD_CYC + 1);
   localparam int WW = $clog2(WDOG_CYC);
   localparam logic [HW-1:0] HOLD_LD  = HW'(HOLD_CYC - 1);
   localparam logic [WW-1:0] WDOG_MAX = WW'(WDOG_CYC - 1);
   state_t           state_q, state_d;
   logic [HW-1:0]    hold_q, hold_d;
   logic [WW-1:0]    wdog_q, wdog_d;
   logic [ALT_W-1:0] alt_q, alt_d;
   logic [DIR_W-1:0] dir_q, dir_d;
   logic [1:0]       gid_q, gid_d;
   logic             act_q, act_d;
   logic             trip_q, trip_d;
   logic [2:0]       rdy;
   logic             acc;
   logic [1:0]       acc_id;
   logic             expire;
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= READY;
         hold_q  <= '0;
         wdog_q  <= '0;
         alt_q   <= ALT_NEUTRAL;
         dir_q   <= DIR_NEUTRAL;
         gid_q   <= 2'd3;
         act_q   <= 1'b0;
         trip_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         wdog_q  <= wdog_d;
         alt_q   <= alt_d;
         dir_q   <= dir_d;
         gid_q   <= gid_d;
         act_q   <= act_d;
         trip_q  <= trip_d;
      end
   end
   // In READY, v & -v isolates the lowest set bit, i.e. the highest-priority source.
   // In HOLD only the failsafe may get through, and only if it does not already own the command.
   always_comb begin
      rdy = (state_q == READY) ? (bus.req_valid & (~bus.req_valid + 3'd1))
                               : {2'b00, bus.req_valid[0] & (gid_q != 2'd0)};
   end
   assign acc    = |rdy;
   assign acc_id = rdy[0] ? 2'd0 : rdy[1] ? 2'd1 : 2'd2;
   assign expire = !acc && (wdog_q == WDOG_MAX);
   always_comb begin
      state_d = acc ? HOLD
              : expire ? READY
              : (state_q == HOLD && hold_q == '0) ? READY : state_q;
      hold_d  = acc ? HOLD_LD
              : (state_q == HOLD && hold_q != '0) ? hold_q - HW'(1) : hold_q;
      wdog_d  = acc ? '0 : (wdog_q == WDOG_MAX) ? wdog_q : wdog_q + WW'(1);
      alt_d   = acc ? bus.req_alt[acc_id*ALT_W +: ALT_W] : expire ? ALT_NEUTRAL : alt_q;
      dir_d   = acc ? bus.req_dir[acc_id*DIR_W +: DIR_W] : expire ? DIR_NEUTRAL : dir_q;
      gid_d   = acc ? acc_id : expire ? 2'd3 : gid_q;
      act_d   = acc ? 1'b1 : expire ? 1'b0 : act_q;
      trip_d  = acc ? 1'b0 : expire ? 1'b1 : trip_q;
   end
   assign bus.req_ready = rdy;
   assign bus.altcmd    = alt_q;
   assign bus.dircmd    = dir_q;
   assign bus.grant_id  = gid_q;
   assign bus.active    = act_q;
   assign bus.wdog_trip = trip_q;
endmodule

// File: tb/tb_flight_cmd_sched.sv
// tb_flight_cmd_sched: directed self-checking bench for flight_cmd_sched
module tb_flight_cmd_sched;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   total = 0;
   int   bad = 0;
   flight_cmd_sched_if bus ();
   flight_cmd_sched dut (.clk(clk), .resetn(resetn), .bus(bus));
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic set_src(input int i, input logic [1:0] a, input logic [2:0] d);
      bus.req_alt[i*2 +: 2] = a;
      bus.req_dir[i*3 +: 3] = d;
   endtask
   task automatic test_reset();
      resetn = 1'b0;
      bus.req_valid = 3'b000;
      bus.req_alt = '0;
      bus.req_dir = '0;
      #2;
      tick();
      total++; if (bus.altcmd !== 2'd0) begin bad++; $display("FAIL rst_alt got=%0d exp=0", bus.altcmd); end
      total++; if (bus.dircmd !== 3'd0) begin bad++; $display("FAIL rst_dir got=%0d exp=0", bus.dircmd); end
      total++; if (bus.grant_id !== 2'd3) begin bad++; $display("FAIL rst_gid got=%0d exp=3", bus.grant_id); end
      total++; if (bus.active !== 1'b0) begin bad++; $display("FAIL rst_active got=%b exp=0", bus.active); end
      total++; if (bus.wdog_trip !== 1'b0) begin bad++; $display("FAIL rst_trip got=%b exp=0", bus.wdog_trip); end
      total++; if (bus.req_ready !== 3'b000) begin bad++; $display("FAIL rst_ready got=%b exp=000", bus.req_ready); end
   endtask
   task automatic test_priority();
      resetn = 1'b1;
      set_src(1, 2'd2, 3'd5);
      set_src(2, 2'd1, 3'd3);
      bus.req_valid = 3'b110;
      #1;
      total++; if (bus.req_ready !== 3'b010) begin bad++; $display("FAIL prio_ready got=%b exp=010", bus.req_ready); end
      tick();
      total++; if (bus.altcmd !== 2'd2) begin bad++; $display("FAIL prio_alt got=%0d exp=2", bus.altcmd); end
      total++; if (bus.dircmd !== 3'd5) begin bad++; $display("FAIL prio_dir got=%0d exp=5", bus.dircmd); end
      total++; if (bus.grant_id !== 2'd1) begin bad++; $display("FAIL prio_gid got=%0d exp=1", bus.grant_id); end
      total++; if (bus.active !== 1'b1) begin bad++; $display("FAIL prio_active got=%b exp=1", bus.active); end
      bus.req_valid = 3'b100;
      for (int k = 0; k < 8; k++) begin
         #1;
         total++; if (bus.req_ready !== 3'b000) begin bad++; $display("FAIL prio_hold_ready k=%0d got=%b exp=000", k, bus.req_ready); end
         tick();
      end
      total++; if (bus.req_ready !== 3'b100) begin bad++; $display("FAIL prio_pilot_ready got=%b exp=100", bus.req_ready); end
      tick();
      bus.req_valid = 3'b000;
      total++; if (bus.grant_id !== 2'd2) begin bad++; $display("FAIL prio_pilot_gid got=%0d exp=2", bus.grant_id); end
      total++; if (bus.altcmd !== 2'd1 || bus.dircmd !== 3'd3) begin bad++; $display("FAIL prio_pilot_cmd got=%0d/%0d exp=1/3", bus.altcmd, bus.dircmd); end
   endtask
   task automatic test_dwell();
      repeat (9) tick();
      set_src(2, 2'd3, 3'd7);
      bus.req_valid = 3'b100;
      #1;
      total++; if (bus.req_ready !== 3'b100) begin bad++; $display("FAIL dwell_ready0 got=%b exp=100", bus.req_ready); end
      tick();
      total++; if (bus.altcmd !== 2'd3 || bus.dircmd !== 3'd7) begin bad++; $display("FAIL dwell_cmd1 got=%0d/%0d exp=3/7", bus.altcmd, bus.dircmd); end
      set_src(2, 2'd1, 3'd6);
      for (int k = 0; k < 8; k++) begin
         #1;
         total++; if (bus.req_ready[2] !== 1'b0 || bus.altcmd !== 2'd3) begin bad++; $display("FAIL dwell_block k=%0d ready2=%b alt=%0d exp ready2=0 alt=3", k, bus.req_ready[2], bus.altcmd); end
         tick();
      end
      tick();
      bus.req_valid = 3'b000;
      total++; if (bus.altcmd !== 2'd1 || bus.dircmd !== 3'd6) begin bad++; $display("FAIL dwell_cmd2 got=%0d/%0d exp=1/6", bus.altcmd, bus.dircmd); end
   endtask
   task automatic test_preempt();
      repeat (9) tick();
      set_src(2, 2'd2, 3'd2);
      bus.req_valid = 3'b100;
      tick();
      bus.req_valid = 3'b000;
      tick();
      tick();
      set_src(0, 2'd3, 3'd0);
      bus.req_valid = 3'b001;
      #1;
      total++; if (bus.req_ready !== 3'b001) begin bad++; $display("FAIL pre_ready got=%b exp=001", bus.req_ready); end
      tick();
      total++; if (bus.grant_id !== 2'd0) begin bad++; $display("FAIL pre_gid got=%0d exp=0", bus.grant_id); end
      total++; if (bus.altcmd !== 2'd3 || bus.dircmd !== 3'd0) begin bad++; $display("FAIL pre_cmd got=%0d/%0d exp=3/0", bus.altcmd, bus.dircmd); end
      total++; if (bus.req_ready !== 3'b000) begin bad++; $display("FAIL pre_self_block got=%b exp=000", bus.req_ready); end
      bus.req_valid = 3'b100;
      for (int k = 0; k < 8; k++) begin
         #1;
         total++; if (bus.req_ready !== 3'b000) begin bad++; $display("FAIL pre_rehold k=%0d got=%b exp=000", k, bus.req_ready); end
         tick();
      end
      total++; if (bus.req_ready !== 3'b100) begin bad++; $display("FAIL pre_release got=%b exp=100", bus.req_ready); end
      bus.req_valid = 3'b000;
   endtask
   task automatic test_watchdog();
      set_src(2, 2'd2, 3'd3);
      bus.req_valid = 3'b100;
      tick();
      bus.req_valid = 3'b000;
      repeat (999) tick();
      total++; if (bus.active !== 1'b1 || bus.wdog_trip !== 1'b0 || bus.grant_id !== 2'd2) begin bad++; $display("FAIL wd_pre active=%b trip=%b gid=%0d exp 1/0/2", bus.active, bus.wdog_trip, bus.grant_id); end
      tick();
      total++; if (bus.altcmd !== 2'd0 || bus.dircmd !== 3'd0) begin bad++; $display("FAIL wd_cmd got=%0d/%0d exp=0/0", bus.altcmd, bus.dircmd); end
      total++; if (bus.grant_id !== 2'd3) begin bad++; $display("FAIL wd_gid got=%0d exp=3", bus.grant_id); end
      total++; if (bus.active !== 1'b0 || bus.wdog_trip !== 1'b1) begin bad++; $display("FAIL wd_flags active=%b trip=%b exp 0/1", bus.active, bus.wdog_trip); end
      tick();
      total++; if (bus.wdog_trip !== 1'b1) begin bad++; $display("FAIL wd_sticky got=%b exp=1", bus.wdog_trip); end
      set_src(1, 2'd1, 3'd1);
      bus.req_valid = 3'b010;
      tick();
      bus.req_valid = 3'b000;
      total++; if (bus.wdog_trip !== 1'b0 || bus.grant_id !== 2'd1 || bus.altcmd !== 2'd1) begin bad++; $display("FAIL wd_clear trip=%b gid=%0d alt=%0d exp 0/1/1", bus.wdog_trip, bus.grant_id, bus.altcmd); end
   endtask
   task automatic test_async_reset();
      #3;
      resetn = 1'b0;
      #1;
      total++; if (bus.altcmd !== 2'd0 || bus.dircmd !== 3'd0) begin bad++; $display("FAIL ar_cmd got=%0d/%0d exp=0/0", bus.altcmd, bus.dircmd); end
      total++; if (bus.grant_id !== 2'd3 || bus.active !== 1'b0 || bus.wdog_trip !== 1'b0) begin bad++; $display("FAIL ar_flags gid=%0d active=%b trip=%b exp 3/0/0", bus.grant_id, bus.active, bus.wdog_trip); end
      #2;
      resetn = 1'b1;
      tick();
      set_src(2, 2'd3, 3'd5);
      bus.req_valid = 3'b100;
      #1;
      total++; if (bus.req_ready !== 3'b100) begin bad++; $display("FAIL ar_ready got=%b exp=100", bus.req_ready); end
      tick();
      bus.req_valid = 3'b000;
      total++; if (bus.grant_id !== 2'd2 || bus.altcmd !== 2'd3 || bus.dircmd !== 3'd5 || bus.active !== 1'b1) begin bad++; $display("FAIL ar_accept gid=%0d alt=%0d dir=%0d active=%b exp 2/3/5/1", bus.grant_id, bus.altcmd, bus.dircmd, bus.active); end
   endtask
   initial begin
      test_reset();
      test_priority();
      test_dwell();
      test_preempt();
      test_watchdog();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
